player_input_frontend: RTL
==========================

// Module: player_input_frontend
// PURPOSE
// - Producer side of the arbiter game's player request lines: turns two raw active-low push buttons into clean, latched requests.
// - Per player: synchronise, debounce, detect the press edge, then latch the request until the round FSM clears it.
// - Also reports which player pressed first; sits between the io_in button pins and the game FSM's req inputs.
// PARAMETERS
// - CLOCK_FREQ      1000  system clock in Hz (game clock rate)
// - DEBOUNCE_MS     20    debounce window in ms
// - DEBOUNCE_COUNT  CLOCK_FREQ*DEBOUNCE_MS/1000 (=20)  mismatch cycles needed to accept a new level; must be >=1
// PORTS
// - clk            in   1  system clock, rising edge
// - reset          in   1  asynchronous, active-high reset
// - player_1_in_n  in   1  raw player 1 button, active low, asynchronous
// - player_2_in_n  in   1  raw player 2 button, active low, asynchronous
// - arm_in         in   1  1 = response window open (countdown finished); presses accepted
// - clear_in       in   1  1 = end of round; clears all latched state
// - req1_out       out  1  player 1 request, sticky until clear_in
// - req2_out       out  1  player 2 request, sticky until clear_in
// - first_out      out  2  first presser: 00 none, 01 P1, 10 P2, 11 same-cycle tie
// - foul_out       out  2  [0]=P1, [1]=P2 false start (only with FALSE_START_EN; otherwise tied 00)
// BEHAVIOUR
// - Reset: sync flops=1, stable levels=1 (released), counters=0, req1/req2=0, first_out=00, foul_out=00.
// - Sync: 2-flop synchroniser per button; no logic on the first stage.
// - Debounce, per channel:
//   - When synced != stable: counter increments each cycle; at count DEBOUNCE_COUNT-1, stable<=synced and counter<=0.
//   - Any cycle with synced == stable resets the counter to 0 (glitch rejection).
// - Press event: the edge where stable goes 1->0. Release (0->1) is debounced the same way but produces no event.
// - Latency: a clean low level first sampled at edge N sets req at edge N+DEBOUNCE_COUNT+1 (arm_in sampled at that edge).
// - Latch: on a press event with arm_in=1 and req not already set, req<=1; it holds until clear_in.
// - first_out: written only while it is 00; set on the first accepted latch; both accepted in the same cycle -> 11.
// - clear_in: req1/req2, first_out and foul_out <= 0 on that edge; it wins over any press event in the same cycle.
//   - Debounce state is not touched: a button still held gives no new event until released and pressed again.
// - arm_in=0: press events are discarded; reqs already latched stay latched.
// - Reset mid-debounce or mid-round: immediate return to reset values; no request survives.
// CONFIGURATION
// - FALSE_START_EN defined:
//   - A press event with arm_in=0 sets that player's foul_out bit (sticky until clear_in or reset).
//   - A fouled player's press events are ignored even after arm_in rises; the other player can still latch and take first_out.
// - FALSE_START_EN undefined: foul_out constant 00; early presses are silently discarded.
// STRUCTURE
// - Shared header arbiter_game_defs.vh holds:
//   - CLOCK_FREQ default
//   - first_out encodings: FIRST_NONE=2'b00, FIRST_P1=2'b01, FIRST_P2=2'b10, FIRST_TIE=2'b11
// - Sub-module button_debouncer (synchroniser + counter + stable register + fall-event output), instantiated once per player.
// - Latch, first-presser and foul logic stay in this module.
// TESTING (DEBOUNCE_COUNT=20 unless noted)
// - Reset: assert reset with buttons low -> all outputs 0 immediately; after release no req until a 20-cycle clean low.
// - Clean press: arm_in=1, player_1_in_n low from edge 10 -> req1_out=1 at edge 31, first_out=01; req2_out stays 0.
// - Glitch: 15-cycle low pulse, then high -> no req; a later 25-cycle low -> req1 set 21 edges after the low starts.
// - Tie: both buttons fall at the same edge with arm_in=1 -> req1=req2=1 on the same edge, first_out=11.
// - Order + clear: P2 latches, then P1 latches 5 cycles later -> first_out=10; clear_in=1 coinciding with a new P1 event -> all 0 next cycle.
// - FALSE_START_EN: P1 press with arm_in=0 -> foul_out=01, no req; arm_in=1, P1 re-presses and P2 presses -> only req2=1, first_out=10.

Source files
------------

// File: rtl/player_input_frontend_pkg.sv
// Shared definitions for the arbiter game's button front end: default clock rate
// and the first-presser encodings.
package player_input_frontend_pkg;

  localparam int CLOCK_FREQ_DEF = 1000;

  localparam logic [1:0] FIRST_NONE = 2'b00;
  localparam logic [1:0] FIRST_P1   = 2'b01;
  localparam logic [1:0] FIRST_P2   = 2'b10;
  localparam logic [1:0] FIRST_TIE  = 2'b11;

  // Accept vector {p2,p1} maps directly onto the first-presser code.
  function automatic logic [1:0] first_code(input logic [1:0] acc);
    return acc;
  endfunction

endpackage

// File: rtl/player_input_frontend_button_debouncer.sv
// One button channel: 2-flop synchroniser, mismatch counter, stable level and a
// single-cycle fall (press) event aligned with the stable register update.
module button_debouncer #(
  parameter int DEBOUNCE_COUNT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic fall_o
);

  localparam int CW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any agreeing cycle restarts the count, so short glitches never get through.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_COUNT - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Event fires on the same edge the stable level drops, so req can latch then.
  assign fall_o = stable_q & ~stable_d;

endmodule

// File: rtl/player_input_frontend.sv
// Two-player button front end: debounced press events latched into sticky
// requests plus first-presser reporting. Optional FALSE_START_EN adds foul tracking.
module player_input_frontend
  import player_input_frontend_pkg::*;
#(
  parameter int CLOCK_FREQ  = CLOCK_FREQ_DEF,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       player_1_in_n,
  input  logic       player_2_in_n,
  input  logic       arm_in,
  input  logic       clear_in,
  output logic       req1_out,
  output logic       req2_out,
  output logic [1:0] first_out,
  output logic [1:0] foul_out
);

  localparam int DEBOUNCE_COUNT = CLOCK_FREQ * DEBOUNCE_MS / 1000;

  logic [1:0] btn_n;
  logic [1:0] ev;
  logic [1:0] acc;
  logic [1:0] req_q, req_d;
  logic [1:0] first_q, first_d;
  logic [1:0] foul_blk;

  assign btn_n = {player_2_in_n, player_1_in_n};

  for (genvar p = 0; p < 2; p++) begin : g_btn
    button_debouncer #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_deb (
      .clk     (clk),
      .rst     (reset),
      .btn_n_i (btn_n[p]),
      .fall_o  (ev[p])
    );
  end

`ifdef FALSE_START_EN
  logic [1:0] foul_q, foul_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) foul_q <= 2'b00;
    else       foul_q <= foul_d;
  end

  // A press before the window opens disqualifies that player for the round.
  always_comb begin
    foul_d = foul_q | (ev & ~{2{arm_in}});
    if (clear_in) foul_d = 2'b00;
  end

  assign foul_blk = foul_q;
  assign foul_out = foul_q;
`else
  assign foul_blk = 2'b00;
  assign foul_out = 2'b00;
`endif

  assign acc = ev & {2{arm_in}} & ~req_q & ~foul_blk;

  always_comb begin
    req_d   = req_q | acc;
    first_d = first_q;
    if (first_q == FIRST_NONE && acc != 2'b00) first_d = first_code(acc);
    if (clear_in) begin
      req_d   = 2'b00;
      first_d = FIRST_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= 2'b00;
      first_q <= FIRST_NONE;
    end else begin
      req_q   <= req_d;
      first_q <= first_d;
    end
  end

  assign req1_out  = req_q[0];
  assign req2_out  = req_q[1];
  assign first_out = first_q;

endmodule
